// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 32-bit memory between instruction fetch and the data stage.
//   Data has priority; a starvation counter forces a fetch grant after MAX_STARVE lost arbitrations.
//   Each granted transaction is held on the mem_* bus until mem_ack or a timeout abort (sticky bus_err_o).
// Ports:
//   clk_i, rst_ni                  clock (rising edge), asynchronous active-low reset
//   if_req_i/if_addr_i             fetch request (level, held until if_ack_o) and address
//   if_ack_o/if_rdata_o            fetch done pulse and instruction (held between acks)
//   d_req_i/d_we_i/d_addr_i/d_wdata_i  data request (level), store flag, address, store data
//   d_ack_o/d_rdata_o              data done pulse and load data (held between acks)
//   stall_f_o/stall_m_o            requester waiting: req & ~ack
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  registered memory transaction
//   mem_ack_i/mem_rdata_i          memory done pulse with same-cycle read data
//   bus_err_o                      sticky timeout flag
module mem_port_arbiter #(
    parameter int unsigned MAX_STARVE = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_ack_o,
    output logic [31:0] d_rdata_o,
    output logic        stall_f_o,
    output logic        stall_m_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        bus_err_o
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic        busy, done, abort, arb, if_elig, d_elig, grant_d, grant_i;
    logic [31:0] ack_data;

    // Arbitration runs in IDLE and on a completing BUSY cycle; the requester
    // just acked still shows its stale level request and must not win again.
    always_comb begin
        busy    = state_q != IDLE;
        done    = busy && mem_ack_i;
        abort   = busy && !mem_ack_i && tmo_q == TMO_LAST;
        arb     = state_q == IDLE || done;
        if_elig = if_req_i && !(done && state_q == BUSY_I);
        d_elig  = d_req_i && !(done && state_q == BUSY_D);
        grant_d = arb && d_elig && !(if_elig && starve_q == STARVE_MAX);
        grant_i = arb && if_elig && !grant_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    // An abort never chains into another grant; the bus always returns to IDLE first.
    always_comb begin
        state_d = abort ? IDLE : grant_d ? BUSY_D : grant_i ? BUSY_I : arb ? IDLE : state_q;
    end

    always_comb begin
        if_ack_o    = state_q == BUSY_I && (mem_ack_i || abort);
        d_ack_o     = state_q == BUSY_D && (mem_ack_i || abort);
        ack_data    = mem_ack_i ? mem_rdata_i : ERR_DATA;
        if_rdata_o  = if_ack_o ? ack_data : if_rdata_q;
        d_rdata_o   = d_ack_o ? ack_data : d_rdata_q;
        stall_f_o   = if_req_i && !if_ack_o;
        stall_m_o   = d_req_i && !d_ack_o;
        mem_req_o   = busy;
        mem_we_o    = mem_we_q;
        mem_addr_o  = mem_addr_q;
        mem_wdata_o = mem_wdata_q;
        bus_err_o   = bus_err_q;
    end

    // Fetch grants leave mem_wdata untouched; it is meaningless for a read.
    always_comb begin
        mem_we_d    = grant_d ? d_we_i : grant_i ? 1'b0 : mem_we_q;
        mem_addr_d  = grant_d ? d_addr_i : grant_i ? if_addr_i : mem_addr_q;
        mem_wdata_d = grant_d ? d_wdata_i : mem_wdata_q;
        starve_d    = grant_i ? 4'd0 :
                      (grant_d && if_elig && starve_q != STARVE_MAX) ? starve_q + 4'd1 : starve_q;
        tmo_d       = (grant_d || grant_i) ? 8'd0 : (busy && !mem_ack_i) ? tmo_q + 8'd1 : tmo_q;
        bus_err_d   = bus_err_q || abort;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            starve_q    <= '0;
            tmo_q       <= '0;
            bus_err_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            bus_err_q   <= bus_err_d;
            if_rdata_q  <= if_rdata_o;
            d_rdata_q   <= d_rdata_o;
        end
    end
endmodule
